// File: rtl/arc4_sched.sv
// arc4_sched: sequences the ARC4 init, ksa and prga sub-blocks over a shared
// single-port S memory, with a per-phase watchdog.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   en, rdy, err              start request, ready-to-accept, watchdog abort flag
//   phase                     S memory owner: 0 none, 1 init, 2 ksa, 3 prga
//   key, key_q                key input (sampled on accepted en) and latched copy
//   init_en/ksa_en/prga_en    one-cycle start pulses to the sub-blocks
//   init_rdy/ksa_rdy/prga_rdy sub-block ready flags (high = idle or done)
//   <blk>_addr/_wrdata/_wren  per-block S memory requests
//   s_addr/s_wrdata/s_wren    S memory port, muxed by phase
module arc4_sched #(
    parameter int TIMEOUT = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic        err,
    output logic [1:0]  phase,
    input  logic [23:0] key,
    output logic [23:0] key_q,
    output logic        init_en,
    output logic        ksa_en,
    output logic        prga_en,
    input  logic        init_rdy,
    input  logic        ksa_rdy,
    input  logic        prga_rdy,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_wrdata,
    input  logic        init_wren,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  ksa_wrdata,
    input  logic        ksa_wren,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  prga_wrdata,
    input  logic        prga_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_GO   = 4'd1,
        ST_INIT_ARM  = 4'd2,
        ST_INIT_WAIT = 4'd3,
        ST_KSA_GO    = 4'd4,
        ST_KSA_ARM   = 4'd5,
        ST_KSA_WAIT  = 4'd6,
        ST_PRGA_GO   = 4'd7,
        ST_PRGA_ARM  = 4'd8,
        ST_PRGA_WAIT = 4'd9,
        ST_ABORT     = 4'd10
    } state_t;

    localparam logic [14:0] WD_LAST = 15'(TIMEOUT - 1);
    localparam logic [14:0] WD_MAX  = 15'h7FFF;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        abort_s;
    logic [14:0] wd_r;
    logic        rdy_r;
    logic        err_r;
    logic [1:0]  phase_r;
    logic [23:0] key_q_r;
    logic        init_en_r;
    logic        ksa_en_r;
    logic        prga_en_r;

    // S memory owner for a given state; unknown encodings own nothing.
    function automatic logic [1:0] phase_of(input state_t st);
        case (st)
            ST_INIT_GO, ST_INIT_ARM, ST_INIT_WAIT: phase_of = 2'd1;
            ST_KSA_GO,  ST_KSA_ARM,  ST_KSA_WAIT:  phase_of = 2'd2;
            ST_PRGA_GO, ST_PRGA_ARM, ST_PRGA_WAIT: phase_of = 2'd3;
            default:                               phase_of = 2'd0;
        endcase
    endfunction

    function automatic logic is_go(input state_t st);
        is_go = (st == ST_INIT_GO) || (st == ST_KSA_GO) || (st == ST_PRGA_GO);
    endfunction

    // The watchdog only runs while a sub-block is expected to be busy.
    function automatic logic is_arm_wait(input state_t st);
        case (st)
            ST_INIT_ARM, ST_INIT_WAIT,
            ST_KSA_ARM,  ST_KSA_WAIT,
            ST_PRGA_ARM, ST_PRGA_WAIT: is_arm_wait = 1'b1;
            default:                   is_arm_wait = 1'b0;
        endcase
    endfunction

    // Next-state logic; completion is tested before the watchdog so it wins a tie.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_ABORT: begin
                if (en) begin
                    state_s  = ST_INIT_GO;
                    accept_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_INIT_GO:   state_s = init_rdy ? ST_INIT_ARM : ST_INIT_GO;
            ST_INIT_ARM:  state_s = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (init_rdy) begin
                    state_s = ST_KSA_GO;
                end else if (wd_r == WD_LAST) begin
                    state_s = ST_ABORT;
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_INIT_WAIT;
                end
            end
            ST_KSA_GO:    state_s = ksa_rdy ? ST_KSA_ARM : ST_KSA_GO;
            ST_KSA_ARM:   state_s = ST_KSA_WAIT;
            ST_KSA_WAIT: begin
                if (ksa_rdy) begin
                    state_s = ST_PRGA_GO;
                end else if (wd_r == WD_LAST) begin
                    state_s = ST_ABORT;
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_KSA_WAIT;
                end
            end
            ST_PRGA_GO:   state_s = prga_rdy ? ST_PRGA_ARM : ST_PRGA_GO;
            ST_PRGA_ARM:  state_s = ST_PRGA_WAIT;
            ST_PRGA_WAIT: begin
                if (prga_rdy) begin
                    state_s = ST_IDLE;
                end else if (wd_r == WD_LAST) begin
                    state_s = ST_ABORT;
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_PRGA_WAIT;
                end
            end
            default:      state_s = ST_IDLE;
        endcase
    end

    // State, watchdog and registered outputs; outputs track the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wd_r      <= 15'd0;
            rdy_r     <= 1'b1;
            err_r     <= 1'b0;
            phase_r   <= 2'd0;
            key_q_r   <= 24'd0;
            init_en_r <= 1'b0;
            ksa_en_r  <= 1'b0;
            prga_en_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (is_go(state_s)) begin
                wd_r <= 15'd0;
            end else if (is_arm_wait(state_r) && (wd_r != WD_MAX)) begin
                wd_r <= wd_r + 15'd1;
            end else begin
                wd_r <= wd_r;
            end
            rdy_r   <= (state_s == ST_IDLE) || (state_s == ST_ABORT);
            phase_r <= phase_of(state_s);
            if (accept_s) begin
                err_r   <= 1'b0;
                key_q_r <= key;
            end else if (abort_s) begin
                err_r   <= 1'b1;
                key_q_r <= key_q_r;
            end else begin
                err_r   <= err_r;
                key_q_r <= key_q_r;
            end
            // The pulse lands in the ARM cycle; ARM then absorbs the
            // sub-block's registered rdy drop.
            init_en_r <= (state_r == ST_INIT_GO) && init_rdy;
            ksa_en_r  <= (state_r == ST_KSA_GO)  && ksa_rdy;
            prga_en_r <= (state_r == ST_PRGA_GO) && prga_rdy;
        end
    end

    // S memory mux: only the owning block reaches the port.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (phase_r)
            2'd1: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            2'd2: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            2'd3: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = 8'd0;
                s_wrdata = 8'd0;
                s_wren   = 1'b0;
            end
        endcase
    end

    assign rdy     = rdy_r;
    assign err     = err_r;
    assign phase   = phase_r;
    assign key_q   = key_q_r;
    assign init_en = init_en_r;
    assign ksa_en  = ksa_en_r;
    assign prga_en = prga_en_r;

endmodule

// File: tb/tb_arc4_sched.sv
module tb_arc4_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rdy, err;
    logic [1:0]  phase;
    logic [23:0] key = 24'd0;
    logic [23:0] key_q;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  init_addr = 8'h33, init_wrdata = 8'h11;
    logic        init_wren = 1'b1;
    logic [7:0]  ksa_addr = 8'h5A, ksa_wrdata = 8'h22;
    logic        ksa_wren = 1'b1;
    logic [7:0]  prga_addr = 8'h7C, prga_wrdata = 8'h44;
    logic        prga_wren = 1'b1;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;

    int total = 0;
    int bad = 0;

    // sub-block stubs: rdy drops for lat cycles after a sampled en
    int  init_lat = 2, ksa_lat = 3, prga_lat = 4;
    int  init_cnt = 0, ksa_cnt = 0, prga_cnt = 0;
    logic stub_clr = 1'b0;
    logic prga_hold = 1'b0;

    // run logs, indexed by cycle number after the en cycle
    int  ph_log [0:63];
    int  rdy_log[0:63];
    int  err_log[0:63];
    int  kq_log [0:63];
    int  sa_log [0:63];
    int  sd_log [0:63];
    int  sw_log [0:63];
    int  ien_log[0:63];
    int  ken_log[0:63];
    int  init_first, ksa_first, prga_first;
    int  init_n, ksa_n, prga_n, done_c;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stub_clr) begin
            init_cnt <= 0; ksa_cnt <= 0; prga_cnt <= 0;
        end else begin
            if (init_en) init_cnt <= init_lat; else if (init_cnt > 0) init_cnt <= init_cnt - 1;
            if (ksa_en)  ksa_cnt  <= ksa_lat;  else if (ksa_cnt > 0)  ksa_cnt  <= ksa_cnt - 1;
            if (prga_en) prga_cnt <= prga_lat; else if (prga_cnt > 0) prga_cnt <= prga_cnt - 1;
        end
    end
    assign init_rdy = (init_cnt == 0);
    assign ksa_rdy  = (ksa_cnt == 0);
    assign prga_rdy = (prga_cnt == 0) && !prga_hold;

    arc4_sched #(.TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .err(err), .phase(phase),
        .key(key), .key_q(key_q),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stubs();
        stub_clr = 1'b1;
        tick();
        stub_clr = 1'b0;
    endtask

    // Pulse en with key k at cycle 0, then log ncyc cycles. Optional actions:
    // release prga_hold at rel_c, raise rst during rst_c, busy en during busy_c.
    task automatic run(input int ncyc, input int rel_c, input int rst_c,
                       input int busy_c, input logic [23:0] k);
        key = k;
        en  = 1'b1;
        init_first = -1; ksa_first = -1; prga_first = -1;
        init_n = 0; ksa_n = 0; prga_n = 0; done_c = -1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == 1) en = 1'b0;
            ph_log[c]  = int'(phase);
            rdy_log[c] = int'(rdy);
            err_log[c] = int'(err);
            kq_log[c]  = int'(key_q);
            sa_log[c]  = int'(s_addr);
            sd_log[c]  = int'(s_wrdata);
            sw_log[c]  = int'(s_wren);
            ien_log[c] = int'(init_en);
            ken_log[c] = int'(ksa_en);
            if (init_en) begin if (init_first < 0) init_first = c; init_n++; end
            if (ksa_en)  begin if (ksa_first  < 0) ksa_first  = c; ksa_n++;  end
            if (prga_en) begin if (prga_first < 0) prga_first = c; prga_n++; end
            if (rdy && done_c < 0) done_c = c;
            if (c == rel_c) prga_hold = 1'b0;
            if (c == busy_c) begin en = 1'b1; key = 24'hABCDEF; end
            if (c == busy_c + 1) en = 1'b0;
            if (c == rst_c) rst = 1'b1;
            if (c == rst_c + 1) rst = 1'b0;
        end
    endtask

    initial begin
        // reset state, with all sub-blocks requesting writes
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy", rdy, 1);
        chk("rst_err", err, 0);
        chk("rst_phase", phase, 0);
        chk("rst_key_q", key_q, 0);
        chk("rst_en_pulses", {init_en, ksa_en, prga_en}, 0);
        chk("rst_s_wren", s_wren, 0);
        chk("rst_s_addr", s_addr, 0);
        tick();
        chk("idle_hold_rdy", rdy, 1);

        // nominal sequence, latencies 2/3/4
        run(25, -1, -1, -1, 24'h000018);
        chk("nom_init_pulse_cyc", init_first, 2);
        chk("nom_ksa_pulse_cyc", ksa_first, 7);
        chk("nom_prga_pulse_cyc", prga_first, 13);
        chk("nom_pulse_counts", {init_n[7:0], ksa_n[7:0], prga_n[7:0]}, 24'h010101);
        chk("nom_done_cyc", done_c, 19);
        chk("nom_rdy_low_c1", rdy_log[1], 0);
        chk("nom_key_q", kq_log[1], 24'h000018);
        chk("nom_phase_init", ph_log[3], 1);
        chk("nom_phase_ksa", ph_log[9], 2);
        chk("nom_phase_prga", ph_log[15], 3);
        chk("nom_phase_done", ph_log[19], 0);
        chk("mux_init_addr", sa_log[2], 8'h33);
        chk("mux_ksa_addr", sa_log[7], 8'h5A);
        chk("mux_ksa_wrdata", sd_log[7], 8'h22);
        chk("mux_ksa_wren", sw_log[7], 1);
        chk("mux_prga_addr", sa_log[13], 8'h7C);
        chk("mux_idle_wren", sw_log[19], 0);
        chk("mux_idle_addr", sa_log[20], 0);
        chk("nom_idle_rdy_c25", rdy_log[25], 1);
        chk("nom_key_q_kept", kq_log[25], 24'h000018);

        // busy gate on prga, released at cycle 15
        clr_stubs();
        prga_hold = 1'b1;
        run(26, 15, -1, -1, 24'h000777);
        chk("gate_phase_prga_go", ph_log[14], 3);
        chk("gate_prga_pulse_cyc", prga_first, 16);
        chk("gate_prga_count", prga_n, 1);
        chk("gate_done_cyc", done_c, 22);

        // watchdog: ksa never comes back
        clr_stubs();
        ksa_lat = 1000;
        run(45, -1, -1, -1, 24'h000018);
        chk("to_err_before", err_log[38], 0);
        chk("to_phase_before", ph_log[38], 2);
        chk("to_err", err_log[39], 1);
        chk("to_rdy", rdy_log[39], 1);
        chk("to_phase", ph_log[39], 0);
        chk("to_s_wren", sw_log[39], 0);
        chk("to_prga_count", prga_n, 0);
        chk("to_err_held", err_log[45], 1);

        // restart from abort, busy en ignored, reset during KSA_WAIT
        clr_stubs();
        ksa_lat = 3;
        run(20, -1, 9, 4, 24'h123456);
        chk("re_err_cleared", err_log[1], 0);
        chk("re_key_q", kq_log[1], 24'h123456);
        chk("busy_key_q", kq_log[6], 24'h123456);
        chk("busy_phase", ph_log[6], 2);
        chk("busy_init_count", init_n, 1);
        chk("mid_phase_ksa_wait", ph_log[9], 2);
        chk("mid_rst_rdy", rdy_log[10], 1);
        chk("mid_rst_phase", ph_log[10], 0);
        chk("mid_rst_ksa_en", ken_log[10], 0);
        chk("mid_rst_s_wren", sw_log[10], 0);
        chk("mid_rst_key_q", kq_log[10], 0);
        chk("mid_rst_err", err_log[10], 0);
        chk("mid_rst_ksa_count", ksa_n, 1);
        chk("mid_rst_prga_count", prga_n, 0);
        chk("mid_rst_idle_c20", rdy_log[20], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arc4_sched.md
ARC4_SCHED -- requirements
Module: arc4_sched

Interface
REQ-001 Parameter TIMEOUT, default 16384: maximum cycles any sub-block phase may stay busy before abort.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset; sampled on rising clk.
REQ-004 en  in  1  start request; accepted only when rdy=1.
REQ-005 rdy  out  1  high when idle or aborted and able to accept en.
REQ-006 err  out  1  high after a watchdog abort; held until the next accepted en or rst.
REQ-007 phase  out  2  owner of the S memory: 0 none, 1 init, 2 ksa, 3 prga.
REQ-008 key  in  24  cipher key, sampled on en acceptance.
REQ-009 key_q  out  24  latched key, driven to the ksa and prga blocks.
REQ-010 init_en / ksa_en / prga_en  out  1 each  one-cycle start pulses to the sub-blocks.
REQ-011 init_rdy / ksa_rdy / prga_rdy  in  1 each  sub-block ready flags (high = idle or done).
REQ-012 init_addr, init_wrdata, init_wren  in  8/8/1  init S-port request.
REQ-013 ksa_addr, ksa_wrdata, ksa_wren  in  8/8/1  ksa S-port request.
REQ-014 prga_addr, prga_wrdata, prga_wren  in  8/8/1  prga S-port request.
REQ-015 s_addr, s_wrdata, s_wren  out  8/8/1  muxed single-port S memory interface.

Function
REQ-016 FSM states: IDLE, INIT_GO, INIT_ARM, INIT_WAIT, KSA_GO, KSA_ARM, KSA_WAIT, PRGA_GO, PRGA_ARM, PRGA_WAIT, ABORT.
REQ-017 IDLE or ABORT with en=1: latch key into key_q, clear err, drive rdy low next cycle, go to INIT_GO.
REQ-018 In IDLE, en=0 holds IDLE; en while rdy=0 is ignored and has no effect.
REQ-019 X_GO: assert X_en for exactly one cycle if X_rdy=1, then go to X_ARM; if X_rdy=0, hold X_GO with X_en=0.
REQ-020 X_ARM: lasts one cycle; ignores X_rdy, which absorbs the sub-block's rdy-drop latency; then go to X_WAIT.
REQ-021 X_WAIT: X_rdy=1 advances INIT to KSA_GO, KSA to PRGA_GO, and PRGA to IDLE with rdy=1 in the following cycle.
REQ-022 Watchdog is a 15-bit counter, cleared on entering each X_GO, incremented in each ARM/WAIT cycle.
REQ-023 Watchdog reaching TIMEOUT-1 while still waiting: go to ABORT with err=1, rdy=1, all X_en=0; the counter saturates and never wraps.
REQ-024 phase is registered: 1 in INIT_*, 2 in KSA_*, 3 in PRGA_*, 0 in IDLE and ABORT.
REQ-025 S mux is combinational on phase: the selected block's addr/wrdata/wren pass through; phase 0 forces s_addr=0, s_wrdata=0, s_wren=0.
REQ-026 Unselected blocks' requests are dropped, so s_wren never reflects an unowned block.
REQ-027 Completion and timeout in the same cycle: completion wins.
REQ-028 Total overhead is 3 cycles per phase beyond the sub-block busy time, plus 1 cycle from en to INIT_GO.

Reset
REQ-029 With rst=1 at a clock edge, the next state is IDLE with rdy=1, err=0, phase=0, all X_en=0, key_q=0, watchdog=0.
REQ-030 A reset mid-operation aborts with no further X_en pulse, and s_wren=0 from the cycle after the edge.
REQ-031 Unknown or illegal state encodings recover to IDLE on the next clock.

Verification
REQ-032 Nominal: key=24'h000018, en pulse; stub rdy low 2/3/4 cycles -> pulses in order init, ksa, prga; rdy=1 after PRGA_WAIT; key_q=24'h000018.
REQ-033 Mux: in phase 2, ksa_addr=8'h5A, ksa_wren=1, init_wren=1 -> s_addr=8'h5A, s_wren=1 from ksa only; phase 0 -> s_wren=0.
REQ-034 Timeout: TIMEOUT=32, ksa_rdy held 0 after its en -> err=1, rdy=1, phase=0 exactly 32 cycles after KSA_GO exit; next en clears err.
REQ-035 Busy gate: prga_rdy=0 when PRGA_GO is entered -> prga_en stays 0 until prga_rdy=1, then one pulse only.
REQ-036 Reset mid-run: rst=1 during KSA_WAIT -> next cycle IDLE, rdy=1, ksa_en=0, s_wren=0; en during busy -> ignored, key_q unchanged.
